huff_code_table: RTL and testbench
==================================

Name: huff_code_table

Overview:
Clocked, tagged successor to the combinational Huffman symbol table, sitting between the tree-walk/lookup block and the decode output stage. Stores one symbol per hashed (length, path) code in a 256-entry array with per-entry valid bit and length tag, so aliased codes miss instead of returning wrong symbols. Adds a registered lookup port, a write handshake, an occupancy counter and a sweeping clear state machine. Symbol width is parametrised.

Parameters:
SYM_W, 8, symbol width in bits.
LEN_W, 4, code-length field width; legal lengths 1..12 (HT_MAX_LEN).
CNT_W, 9, occupancy counter width; must hold 0..256.

Ports:
clk  in  1  system clock.
n_rst  in  1  asynchronous active-low reset.
wr_en  in  1  write request; accepted only when wr_ready=1.
wr_ready  out  1  high in IDLE, low in CLEAR.
wr_length  in  LEN_W  code length of entry being written.
wr_path  in  12  code bits; path[0] is first bit walked.
wr_symbol  in  SYM_W  decoded symbol to store.
save_comp  out  1  one-cycle pulse, cycle after an accepted legal write.
wr_err  out  1  one-cycle pulse, cycle after an accepted write with illegal length.
lk_req  in  1  lookup request.
lk_length  in  LEN_W  lookup code length.
lk_path  in  12  lookup code bits.
lk_valid  out  1  pulse, cycle after lk_req.
lk_hit  out  1  qualified by lk_valid.
lk_symbol  out  SYM_W  stored symbol on hit, 0 on miss.
clear  in  1  start table flush.
busy  out  1  high while in CLEAR.
occupancy  out  CNT_W  number of valid entries.
collision  out  1  sticky overwrite flag (see Optional Feature).

Behaviour:
- Reset (n_rst=0, async): state IDLE; all valid bits, tags, symbols 0; wr_ready=1; save_comp, wr_err, lk_valid, lk_hit, busy, collision = 0; lk_symbol=0; occupancy=0. Reset mid-CLEAR aborts the sweep immediately.
- Hash (package function ht_hash): L 1..7 -> {1'b0, path[6:0]}; 8 -> 128+path[8:3]; 9 -> 192+path[9:5]; 10 -> 224+path[10:7]; 11 -> 240+path[11:9]; 12 -> 248+path[11:9]. All results 8 bits, no overflow. L=0 or L>12 is illegal.
- Write: wr_en && wr_ready && legal length -> at clock edge entry[hash] = {valid=1, tag=wr_length, symbol}; save_comp pulses next cycle. occupancy +1 only if the entry was previously invalid. Illegal length: no array change, wr_err pulses. wr_en while wr_ready=0 is ignored with no pulse; the source holds the request.
- Lookup: lk_req -> one-cycle latency; lk_hit = entry.valid && entry.tag==lk_length (legal length only); lk_symbol = symbol on hit, else 0. Lookups are accepted in any state; lookups in CLEAR always miss. Lookup and write to the same index in the same cycle return the pre-write contents.
- FSM IDLE: clear=1 -> CLEAR, sweep index=0, occupancy forced to 0, busy=1, wr_ready=0 from the next cycle. A write in the same cycle as clear is dropped with no save_comp.
- FSM CLEAR: one entry invalidated per cycle, index 0..255; after index 255 -> IDLE. Sweep takes 256 cycles. clear re-asserted during CLEAR is ignored.
- collision is cleared when CLEAR is entered.

Optional Feature:
HUFF_TABLE_COLLISION_EN.
- Defined: a legal write to an entry already valid with a different tag or different symbol sets collision=1 (sticky until clear or reset). The entry is still overwritten and occupancy is unchanged.
- Undefined: collision tied to 0; no compare logic is built.

Decomposition:
- Package huff_pkg: HT_DEPTH=256, HT_MAX_LEN=12, HT_PATH_W=12, ht_state_t enum {HT_IDLE, HT_CLEAR}, ht_entry_t struct {valid, tag, symbol}, function ht_hash(length, path).
- Optional sub-module ht_hash_unit: combinational, instantiated twice (write side, lookup side) so one hash definition is shared by both ports. Everything else lives in the top module.

Test Plan:
- Write L=3 path=0x005 sym=0x41 -> save_comp next cycle, occupancy=1. Lookup L=3 path=0x005 -> lk_valid, lk_hit=1, lk_symbol=0x41 one cycle after lk_req.
- Alias check: after the above, lookup L=7 path=0x005 (same index 5) -> lk_hit=0, lk_symbol=0. Write L=7 path=0x005 sym=0x42 -> collision=1 with macro (0 without), occupancy stays 1.
- Hash bounds: write L=12 path=0xE00 sym=0x7F -> index 255. Write L=8 path=0x1F8 -> index 191. Both hit on lookup; occupancy=2.
- Illegal length: write L=0 and L=13 -> wr_err pulse each, no save_comp, occupancy unchanged, lookup misses.
- Clear: fill 10 entries, pulse clear -> busy=1 and wr_ready=0 for 256 cycles, occupancy=0 immediately. A held wr_en is accepted on the first IDLE cycle. All prior lookups miss.
- Reset at sweep index 100 -> busy=0, occupancy=0, collision=0, IDLE next cycle, all entries invalid.

Source files
------------

// File: rtl/huff_pkg.sv
// Shared types, sizes and the (length, path) -> index hash for the
// Huffman code table.
package huff_pkg;

   localparam int HT_DEPTH   = 256;
   localparam int HT_MAX_LEN = 12;
   localparam int HT_PATH_W  = 12;
   localparam int HT_IDX_W   = 8;
   localparam int HT_TAG_W   = 4;
   localparam int HT_SYM_W   = 8;

   typedef enum logic {
      HT_IDLE  = 1'b0,
      HT_CLEAR = 1'b1
   } ht_state_t;

   typedef struct packed {
      logic                valid;
      logic [HT_TAG_W-1:0] tag;
      logic [HT_SYM_W-1:0] symbol;
   } ht_entry_t;

   // Short codes map directly; longer codes pack into the top of the
   // array using only their high path bits.
   function automatic logic [HT_IDX_W-1:0] ht_hash(
      input logic [7:0]           length,
      input logic [HT_PATH_W-1:0] path
   );
      logic [HT_IDX_W-1:0] h;
      h = '0;
      unique case (1'b1)
         (length <= 8'd7):  h = {1'b0, path[6:0]};
         (length == 8'd8):  h = 8'd128 + {2'b0, path[8:3]};
         (length == 8'd9):  h = 8'd192 + {3'b0, path[9:5]};
         (length == 8'd10): h = 8'd224 + {4'b0, path[10:7]};
         (length == 8'd11): h = 8'd240 + {5'b0, path[11:9]};
         (length == 8'd12): h = 8'd248 + {5'b0, path[11:9]};
         default:           h = '0;
      endcase
      return h;
   endfunction

endpackage

// File: rtl/ht_hash_unit.sv
// Combinational hash plus length-legality check, one copy per table port.
// LEN_W is expected to be 8 or less.
module ht_hash_unit
   import huff_pkg::*;
#(
   parameter int LEN_W = 4
) (
   input  logic [LEN_W-1:0]     length,
   input  logic [HT_PATH_W-1:0] path,
   output logic [HT_IDX_W-1:0]  index,
   output logic                 legal
);

   assign legal = (length != '0) &&
                  (length <= LEN_W'(HT_MAX_LEN));

   assign index = ht_hash(8'(length), path);

endmodule

// File: rtl/huff_code_table.sv
// Tagged 256-entry Huffman symbol table with registered lookup, sweep clear.
// Optional macro HUFF_TABLE_COLLISION_EN builds the sticky overwrite flag.
module huff_code_table
   import huff_pkg::*;
#(
   parameter int SYM_W = 8,
   parameter int LEN_W = 4,
   parameter int CNT_W = 9
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 wr_en,
   output logic                 wr_ready,
   input  logic [LEN_W-1:0]     wr_length,
   input  logic [HT_PATH_W-1:0] wr_path,
   input  logic [SYM_W-1:0]     wr_symbol,
   output logic                 save_comp,
   output logic                 wr_err,
   input  logic                 lk_req,
   input  logic [LEN_W-1:0]     lk_length,
   input  logic [HT_PATH_W-1:0] lk_path,
   output logic                 lk_valid,
   output logic                 lk_hit,
   output logic [SYM_W-1:0]     lk_symbol,
   input  logic                 clear,
   output logic                 busy,
   output logic [CNT_W-1:0]     occupancy,
   output logic                 collision
);

   typedef struct packed {
      logic             valid;
      logic [LEN_W-1:0] tag;
      logic [SYM_W-1:0] symbol;
   } entry_t;

   ht_state_t           state;
   logic [HT_IDX_W-1:0] sweep;
   entry_t              ent [HT_DEPTH];

   logic [HT_IDX_W-1:0] w_idx;
   logic [HT_IDX_W-1:0] l_idx;
   logic                w_legal;
   logic                l_legal;
   logic                wr_acc;
   logic                wr_ok;
   logic                lk_match;

   ht_hash_unit #(.LEN_W(LEN_W)) u_wr_hash (
      .length (wr_length),
      .path   (wr_path),
      .index  (w_idx),
      .legal  (w_legal)
   );

   ht_hash_unit #(.LEN_W(LEN_W)) u_lk_hash (
      .length (lk_length),
      .path   (lk_path),
      .index  (l_idx),
      .legal  (l_legal)
   );

   assign wr_ready = (state == HT_IDLE);
   assign busy     = (state == HT_CLEAR);

   // A write colliding with clear is dropped outright.
   assign wr_acc = wr_en && (state == HT_IDLE) && !clear;
   assign wr_ok  = wr_acc && w_legal;

   assign lk_match = lk_req && (state == HT_IDLE) && l_legal &&
                     ent[l_idx].valid &&
                     (ent[l_idx].tag == lk_length);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= HT_IDLE;
         sweep     <= '0;
         occupancy <= '0;
         save_comp <= 1'b0;
         wr_err    <= 1'b0;
         lk_valid  <= 1'b0;
         lk_hit    <= 1'b0;
         lk_symbol <= '0;
         for (int i = 0; i < HT_DEPTH; i++) begin
            ent[i] <= '0;
         end
      end else begin
         save_comp <= wr_ok;
         wr_err    <= wr_acc && !w_legal;
         lk_valid  <= lk_req;
         lk_hit    <= lk_match;
         lk_symbol <= lk_match ? ent[l_idx].symbol : '0;
         if (state == HT_IDLE) begin
            if (clear) begin
               state     <= HT_CLEAR;
               sweep     <= '0;
               occupancy <= '0;
            end else if (wr_ok) begin
               ent[w_idx].valid  <= 1'b1;
               ent[w_idx].tag    <= wr_length;
               ent[w_idx].symbol <= wr_symbol;
               if (!ent[w_idx].valid) begin
                  occupancy <= occupancy + CNT_W'(1);
               end
            end
         end else begin
            ent[sweep].valid <= 1'b0;
            sweep            <= sweep + HT_IDX_W'(1);
            if (sweep == HT_IDX_W'(HT_DEPTH - 1)) begin
               state <= HT_IDLE;
            end
         end
      end
   end

`ifdef HUFF_TABLE_COLLISION_EN
   logic coll_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         coll_q <= 1'b0;
      end else if ((state == HT_IDLE) && clear) begin
         coll_q <= 1'b0;
      end else if (wr_ok && ent[w_idx].valid &&
                   ((ent[w_idx].tag != wr_length) ||
                    (ent[w_idx].symbol != wr_symbol))) begin
         coll_q <= 1'b1;
      end
   end

   assign collision = coll_q;
`else
   assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_huff_code_table.sv
// Scoreboard bench for huff_code_table: random and directed traffic
// against an array model of the table.
module tb_huff_code_table;

`ifdef HUFF_TABLE_COLLISION_EN
   localparam bit COLL_EN = 1'b1;
`else
   localparam bit COLL_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        wr_en = 1'b0;
   logic        wr_ready;
   logic [3:0]  wr_length = '0;
   logic [11:0] wr_path = '0;
   logic [7:0]  wr_symbol = '0;
   logic        save_comp;
   logic        wr_err;
   logic        lk_req = 1'b0;
   logic [3:0]  lk_length = '0;
   logic [11:0] lk_path = '0;
   logic        lk_valid;
   logic        lk_hit;
   logic [7:0]  lk_symbol;
   logic        clear = 1'b0;
   logic        busy;
   logic [8:0]  occupancy;
   logic        collision;

   huff_code_table dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .wr_en     (wr_en),
      .wr_ready  (wr_ready),
      .wr_length (wr_length),
      .wr_path   (wr_path),
      .wr_symbol (wr_symbol),
      .save_comp (save_comp),
      .wr_err    (wr_err),
      .lk_req    (lk_req),
      .lk_length (lk_length),
      .lk_path   (lk_path),
      .lk_valid  (lk_valid),
      .lk_hit    (lk_hit),
      .lk_symbol (lk_symbol),
      .clear     (clear),
      .busy      (busy),
      .occupancy (occupancy),
      .collision (collision)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [8:0] lq [$];
   logic [1:0] wq [$];

   bit m_valid [256];
   int m_tag   [256];
   int m_sym   [256];
   int m_occ = 0;
   bit m_coll = 1'b0;
   int busy_left = 0;
   int pool [16];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int ref_idx(input int l, input int p);
      if (l >= 1 && l <= 7) return p % 128;
      if (l == 8)  return 128 + (p / 8) % 64;
      if (l == 9)  return 192 + (p / 32) % 32;
      if (l == 10) return 224 + (p / 128) % 16;
      if (l == 11) return 240 + (p / 512) % 8;
      if (l == 12) return 248 + (p / 512) % 8;
      return 0;
   endfunction

   function automatic bit legal_len(input int l);
      return (l >= 1) && (l <= 12);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 256; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i] = 0;
         m_sym[i] = 0;
      end
      m_occ = 0;
      m_coll = 1'b0;
      busy_left = 0;
   endtask

   // One cycle of stimulus; expectations queued before the edge,
   // model advanced after it.
   task automatic step(input bit we, input int wl, input int wp,
                       input int ws, input bit lr, input int ll,
                       input int lp, input bit clr, output bit acc);
      bit idle;
      bit hit;
      int li;
      int wi;
      @(negedge clk);
      wr_en = we;
      wr_length = 4'(wl);
      wr_path = 12'(wp);
      wr_symbol = 8'(ws);
      lk_req = lr;
      lk_length = 4'(ll);
      lk_path = 12'(lp);
      clear = clr;
      idle = (busy_left == 0);
      acc = idle && we && !clr;
      if (lr) begin
         li = ref_idx(ll, lp);
         hit = idle && legal_len(ll) && m_valid[li] && (m_tag[li] == ll);
         lq.push_back({hit, hit ? 8'(m_sym[li]) : 8'h00});
      end
      wq.push_back({acc && legal_len(wl), acc && !legal_len(wl)});
      @(posedge clk);
      if (idle && clr) begin
         for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
         m_occ = 0;
         m_coll = 1'b0;
         busy_left = 256;
      end else begin
         if (!idle) busy_left--;
         if (acc && legal_len(wl)) begin
            wi = ref_idx(wl, wp);
            if (m_valid[wi]) begin
               if (m_tag[wi] != wl || m_sym[wi] != ws) m_coll = 1'b1;
            end else begin
               m_occ++;
            end
            m_valid[wi] = 1'b1;
            m_tag[wi] = wl;
            m_sym[wi] = ws;
         end
      end
      #2;
      chk("busy", 32'(busy), 32'(busy_left > 0));
      chk("wr_ready", 32'(wr_ready), 32'(busy_left == 0));
      chk("occupancy", 32'(occupancy), 32'(m_occ));
      chk("collision", 32'(collision), 32'(COLL_EN & m_coll));
      wr_en = 1'b0;
      lk_req = 1'b0;
      clear = 1'b0;
   endtask

   task automatic wr(input int l, input int p, input int s);
      bit a;
      step(1'b1, l, p, s, 1'b0, 0, 0, 1'b0, a);
   endtask

   task automatic lk(input int l, input int p);
      bit a;
      step(1'b0, 0, 0, 0, 1'b1, l, p, 1'b0, a);
   endtask

   always @(posedge clk) begin
      logic [8:0] e;
      logic [1:0] w;
      #1;
      if (n_rst) begin
         if (wq.size() > 0) begin
            w = wq.pop_front();
            chk("save_comp", 32'(save_comp), 32'(w[1]));
            chk("wr_err", 32'(wr_err), 32'(w[0]));
         end
         if (lk_valid) begin
            if (lq.size() == 0) begin
               chk("lk_valid_unexpected", 32'(lk_valid), 32'(0));
            end else begin
               e = lq.pop_front();
               chk("lk_hit", 32'(lk_hit), 32'(e[8]));
               chk("lk_symbol", 32'(lk_symbol), 32'(e[7:0]));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit a;
      int n;
      model_reset();
      for (int i = 0; i < 16; i++) pool[i] = $urandom_range(0, 4095);
      repeat (2) @(negedge clk);
      chk("rst_wr_ready", 32'(wr_ready), 32'(1));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_occupancy", 32'(occupancy), 32'(0));
      chk("rst_lk_valid", 32'(lk_valid), 32'(0));
      chk("rst_lk_hit", 32'(lk_hit), 32'(0));
      chk("rst_lk_symbol", 32'(lk_symbol), 32'(0));
      chk("rst_save_comp", 32'(save_comp), 32'(0));
      chk("rst_wr_err", 32'(wr_err), 32'(0));
      chk("rst_collision", 32'(collision), 32'(0));
      n_rst = 1'b1;

      wr(3, 12'h005, 8'h41);
      lk(3, 12'h005);
      lk(7, 12'h005);
      wr(7, 12'h005, 8'h42);
      wr(12, 12'hE00, 8'h7F);
      wr(8, 12'h1F8, 8'h33);
      lk(12, 12'hE00);
      lk(8, 12'h1F8);
      lk(11, 12'hE00);
      wr(0, 12'h005, 8'h11);
      wr(13, 12'h005, 8'h12);
      lk(0, 12'h005);
      lk(13, 12'h005);
      lk(7, 12'h005);
      step(1'b1, 3, 12'h005, 8'h99, 1'b1, 3, 12'h005, 1'b0, a);
      step(1'b1, 3, 12'h005, 8'h55, 1'b1, 3, 12'h005, 1'b0, a);

      for (int i = 0; i < 10; i++) wr($urandom_range(1, 12), pool[i], i + 1);
      step(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b1, a);
      n = 0;
      a = 1'b0;
      for (int k = 0; k < 300 && !a; k++) begin
         step(1'b1, 5, 12'h013, 8'hA5, 1'b1, 3, 12'h005, k == 50, a);
         if (!a) n++;
      end
      chk("held_write_accepted", 32'(a), 32'(1));
      chk("clear_cycles", 32'(n), 32'(256));
      for (int i = 0; i < 10; i++) lk($urandom_range(1, 12), pool[i]);
      lk(5, 12'h013);

      for (int i = 0; i < 2500; i++) begin
         int wl;
         int ll;
         wl = ($urandom_range(0, 9) == 0) ? 13 * $urandom_range(0, 1)
                                          : $urandom_range(1, 12);
         ll = $urandom_range(1, 12);
         step($urandom_range(0, 99) < 45, wl, pool[$urandom_range(0, 15)],
              $urandom_range(0, 255), $urandom_range(0, 1) == 1, ll,
              pool[$urandom_range(0, 15)], $urandom_range(0, 599) == 0, a);
      end

      for (int i = 0; i < 8; i++) wr($urandom_range(1, 12), pool[i], 8'hC0 + i);
      wr(7, pool[0], 8'h01);
      wr(7, pool[0], 8'h02);
      step(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b1, a);
      for (int i = 0; i < 100; i++) lk(7, pool[0]);
      n_rst = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_busy", 32'(busy), 32'(0));
      chk("mid_rst_wr_ready", 32'(wr_ready), 32'(1));
      chk("mid_rst_occupancy", 32'(occupancy), 32'(0));
      chk("mid_rst_collision", 32'(collision), 32'(0));
      @(negedge clk);
      n_rst = 1'b1;
      for (int i = 0; i < 16; i++) lk($urandom_range(1, 12), pool[i]);
      for (int l = 1; l <= 12; l++) lk(l, pool[0]);
      wr(9, 12'h3E0, 8'h5A);
      lk(9, 12'h3E0);

      repeat (3) @(negedge clk);
      chk("lk_queue_drained", 32'(lq.size()), 32'(0));
      chk("wr_queue_drained", 32'(wq.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
